// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : shared engine opcodes, R/W bit values and arbiter state encoding
// Revision: 1.0
// ============================================================================
package i2c_pkg;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_START = 3'd2,
    ST_ADDR  = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5,
    ST_DONE  = 3'd6
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first set index at/after ptr
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int w_pos;

  // Walk offsets from farthest to nearest so the nearest set index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_pos     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_pos = int'(ptr) + i;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (en && req[w_pos]) begin
        grant        = '0;
        grant[w_pos] = 1'b1;
        grant_idx    = IDX_W'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// i2c_xfer_arbiter : round-robin sharing of a byte-level I2C master engine,
//                    one START/ADDR/DATA/STOP transaction per grant
// Revision: 1.0
// ============================================================================
module i2c_xfer_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [NUM_REQ*7-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]    done,
  output logic                  nack,
  output logic [7:0]            rdata,
  output logic                  busy,
  output logic                  eng_cmd_valid,
  input  logic                  eng_cmd_ready,
  output logic [1:0]            eng_op,
  output logic [7:0]            eng_wdata,
  output logic                  eng_last,
  input  logic                  eng_rsp_valid,
  input  logic                  eng_rsp_nack,
  input  logic [7:0]            eng_rsp_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          r_state;
  logic                r_wait;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_gnt;
  logic [NUM_REQ-1:0]  r_gnt_oh;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
  logic [7:0]          r_rdata_cap;
  logic                r_nack_flag;

  logic [NUM_REQ-1:0]  w_gnt_oh;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_rsp;

  // A response only counts while an op is outstanding.
  assign w_rsp = r_wait & eng_rsp_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req),
    .ptr       (r_ptr),
    .en        (r_state == ST_IDLE),
    .grant     (w_gnt_oh),
    .grant_idx (w_gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_wait        <= 1'b0;
      r_ptr         <= '0;
      r_gnt         <= '0;
      r_gnt_oh      <= '0;
      r_rw          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata_cap   <= '0;
      r_nack_flag   <= 1'b0;
      done          <= '0;
      nack          <= 1'b0;
      rdata         <= '0;
      busy          <= 1'b0;
      eng_cmd_valid <= 1'b0;
      eng_op        <= OP_START;
      eng_wdata     <= '0;
      eng_last      <= 1'b0;
    end else begin
      done <= '0;
      if (eng_cmd_valid && eng_cmd_ready) begin
        eng_cmd_valid <= 1'b0;
        r_wait        <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt       <= w_gnt_idx;
            r_gnt_oh    <= w_gnt_oh;
            r_rw        <= req_rw[w_gnt_idx];
            r_addr      <= req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_wdata     <= req_wdata[w_gnt_idx*8 +: 8];
            r_nack_flag <= 1'b0;
            busy        <= 1'b1;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          eng_cmd_valid <= 1'b1;
          eng_op        <= OP_START;
          eng_wdata     <= '0;
          eng_last      <= 1'b1;
          r_wait        <= 1'b0;
          r_state       <= ST_START;
        end
        ST_START: begin
          if (w_rsp) begin
            eng_cmd_valid <= 1'b1;
            r_wait        <= 1'b0;
            eng_op        <= OP_WRITE;
            eng_wdata     <= {r_addr, r_rw};
            r_state       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_rsp) begin
            eng_cmd_valid <= 1'b1;
            r_wait        <= 1'b0;
            if (eng_rsp_nack) begin
              r_nack_flag <= 1'b1;
              eng_op      <= OP_STOP;
              eng_wdata   <= '0;
              r_state     <= ST_STOP;
            end else if (r_rw == I2C_RW_READ) begin
              eng_op    <= OP_READ;
              eng_wdata <= '0;
              r_state   <= ST_DATA;
            end else begin
              eng_op    <= OP_WRITE;
              eng_wdata <= r_wdata;
              r_state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_rsp) begin
            if (r_rw == I2C_RW_WRITE) begin
              if (eng_rsp_nack) r_nack_flag <= 1'b1;
            end else begin
              r_rdata_cap <= eng_rsp_rdata;
            end
            eng_cmd_valid <= 1'b1;
            r_wait        <= 1'b0;
            eng_op        <= OP_STOP;
            eng_wdata     <= '0;
            r_state       <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Status is published on entry to DONE so it lines up with the pulse.
          if (w_rsp) begin
            r_wait  <= 1'b0;
            done    <= r_gnt_oh;
            nack    <= r_nack_flag;
            if (r_rw == I2C_RW_READ && !r_nack_flag) rdata <= r_rdata_cap;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_ptr   <= (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// tb_i2c_xfer_arbiter : vector table, corner sequences and random rounds
// Revision: 1.0
// ============================================================================
module tb_i2c_xfer_arbiter;
  import i2c_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_rw = '0;
  logic [N*7-1:0] req_addr = '0;
  logic [N*8-1:0] req_wdata = '0;
  logic [N-1:0]   done;
  logic           nack;
  logic [7:0]     rdata;
  logic           busy;
  logic           eng_cmd_valid;
  logic           eng_cmd_ready;
  logic [1:0]     eng_op;
  logic [7:0]     eng_wdata;
  logic           eng_last;
  logic           eng_rsp_valid;
  logic           eng_rsp_nack;
  logic [7:0]     eng_rsp_rdata;

  always #5 clk = ~clk;

  i2c_xfer_arbiter #(.NUM_REQ(N), .ADDR_W(7)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .nack(nack), .rdata(rdata), .busy(busy),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready), .eng_op(eng_op),
    .eng_wdata(eng_wdata), .eng_last(eng_last), .eng_rsp_valid(eng_rsp_valid),
    .eng_rsp_nack(eng_rsp_nack), .eng_rsp_rdata(eng_rsp_rdata)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { logic [1:0] op; logic [7:0] data; logic last; } opr_t;
  opr_t log_q[$];

  int         cfg_stall = 0;
  int         cfg_lat = 0;
  bit         cfg_nack_a = 1'b0;
  bit         cfg_nack_d = 1'b0;
  logic [7:0] cfg_rd = '0;
  bit         scramble = 1'b0;

  int         m_ptr = 0;
  logic [7:0] m_rdata = '0;
  logic       m_rw[N];
  logic [6:0] m_addr[N];
  logic [7:0] m_wd[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] w);
    m_rw[i] = rw; m_addr[i] = a; m_wd[i] = w;
    req_rw[i] = rw; req_addr[i*7 +: 7] = a; req_wdata[i*8 +: 8] = w;
  endtask

  // Winner is the set index with the smallest forward distance from the pointer.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (r[i] && ((i - p + N) % N) < bd) begin
        bd = (i - p + N) % N;
        best = i;
      end
    return best;
  endfunction

  // I2C engine: optional ready stall, response latency, NACK on chosen WRITE.
  initial begin : engine
    int stall_n, lat_n, wr_n;
    bit outst, p_nack;
    logic [1:0] h_op;
    logic [7:0] h_wd;
    stall_n = 0; lat_n = 0; wr_n = 0; outst = 0; p_nack = 0; h_op = '0; h_wd = '0;
    eng_cmd_ready = 0; eng_rsp_valid = 0; eng_rsp_nack = 0; eng_rsp_rdata = '0;
    forever begin
      @(negedge clk); #1;
      eng_cmd_ready = 0; eng_rsp_valid = 0; eng_rsp_nack = 0;
      if (!rstn) begin
        outst = 0; stall_n = 0;
      end else if (outst) begin
        if (lat_n == 0) begin
          eng_rsp_valid = 1; eng_rsp_nack = p_nack; eng_rsp_rdata = cfg_rd; outst = 0;
        end else lat_n--;
      end else if (eng_cmd_valid) begin
        if (stall_n == 0) begin
          h_op = eng_op; h_wd = eng_wdata;
        end else begin
          chk("stall_op", 32'(eng_op), 32'(h_op));
          chk("stall_wdata", 32'(eng_wdata), 32'(h_wd));
        end
        if (stall_n < cfg_stall) stall_n++;
        else begin
          eng_cmd_ready = 1; stall_n = 0; outst = 1; lat_n = cfg_lat;
          log_q.push_back('{eng_op, eng_wdata, eng_last});
          if (eng_op == OP_START) wr_n = 0;
          p_nack = 0;
          if (eng_op == OP_WRITE) begin
            p_nack = (wr_n == 0) ? cfg_nack_a : cfg_nack_d;
            wr_n++;
          end
        end
      end
    end
  end

  task automatic check_txn(input int id, input bit exp_nack, input logic [7:0] exp_rd,
                           input string name);
    opr_t exp_q[$];
    int cyc = 0;
    bit scr = 0;
    exp_q.push_back('{OP_START, 8'h00, 1'b1});
    exp_q.push_back('{OP_WRITE, {m_addr[id], m_rw[id]}, 1'b1});
    if (!cfg_nack_a) begin
      if (m_rw[id]) exp_q.push_back('{OP_READ, 8'h00, 1'b1});
      else          exp_q.push_back('{OP_WRITE, m_wd[id], 1'b1});
    end
    exp_q.push_back('{OP_STOP, 8'h00, 1'b1});
    do begin
      @(negedge clk); cyc++;
      if (scramble && busy && !scr) begin
        scr = 1;
        req_rw = 4'($urandom); req_addr = 28'($urandom); req_wdata = $urandom;
        if ($urandom_range(1, 0) == 1) req[id] = 1'b0;
      end
    end while (done == '0 && cyc < 400);
    if (done == '0) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
      return;
    end
    chk({name, " done"}, 32'(done), 32'(1) << id);
    chk({name, " nack"}, 32'(nack), 32'(exp_nack));
    chk({name, " rdata"}, 32'(rdata), 32'(exp_rd));
    chk({name, " busy_at_done"}, 32'(busy), 32'd1);
    chk({name, " op_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s op%0d", name, i), 32'(log_q[i].op), 32'(exp_q[i].op));
      if (exp_q[i].op == OP_WRITE)
        chk($sformatf("%s op%0d wdata", name, i), 32'(log_q[i].data), 32'(exp_q[i].data));
      if (exp_q[i].op == OP_READ)
        chk($sformatf("%s op%0d last", name, i), 32'(log_q[i].last), 32'd1);
    end
    @(negedge clk);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
    chk({name, " done_pulse"}, 32'(done), 32'd0);
    m_ptr = (id + 1) % N;
    m_rdata = exp_rd;
    log_q.delete();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " done"}, 32'(done), 32'd0);
    chk({name, " nack"}, 32'(nack), 32'd0);
    chk({name, " rdata"}, 32'(rdata), 32'd0);
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " cmd_valid"}, 32'(eng_cmd_valid), 32'd0);
    chk({name, " op"}, 32'(eng_op), 32'd0);
    chk({name, " wdata"}, 32'(eng_wdata), 32'd0);
    chk({name, " last"}, 32'(eng_last), 32'd0);
  endtask

  typedef struct {
    int id; bit rw; bit [6:0] addr; bit [7:0] wd; bit na; bit nd; bit [7:0] erd;
    int stall; int lat; bit exp_nack; bit [7:0] exp_rd;
  } vec_t;

  initial begin : stim
    vec_t vt[7];
    int rr_exp[5];
    int cyc, g;
    logic [N-1:0] rv;
    bit en;
    logic [7:0] er;

    vt[0] = '{0, 1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 0, 0, 1'b0, 8'h00};
    vt[1] = '{2, 1'b1, 7'h1D, 8'h00, 1'b0, 1'b0, 8'h3C, 0, 0, 1'b0, 8'h3C};
    vt[2] = '{1, 1'b1, 7'h7F, 8'h00, 1'b1, 1'b0, 8'h55, 0, 1, 1'b1, 8'h3C};
    vt[3] = '{3, 1'b0, 7'h12, 8'h77, 1'b0, 1'b1, 8'h00, 1, 0, 1'b1, 8'h3C};
    vt[4] = '{1, 1'b1, 7'h22, 8'h00, 1'b0, 1'b0, 8'h99, 5, 2, 1'b0, 8'h99};
    vt[5] = '{0, 1'b0, 7'h50, 8'h5A, 1'b0, 1'b0, 8'h00, 5, 0, 1'b0, 8'h99};
    vt[6] = '{3, 1'b1, 7'h01, 8'h00, 1'b0, 1'b1, 8'hE7, 0, 3, 1'b0, 8'hE7};
    rr_exp = '{0, 1, 2, 3, 0};

    rstn = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1;
    @(negedge clk);

    foreach (vt[v]) begin
      cfg_stall = vt[v].stall; cfg_lat = vt[v].lat; cfg_nack_a = vt[v].na;
      cfg_nack_d = vt[v].nd; cfg_rd = vt[v].erd;
      set_req(vt[v].id, vt[v].rw, vt[v].addr, vt[v].wd);
      req = '0; req[vt[v].id] = 1'b1;
      if (v == 0) begin
        @(negedge clk);
        chk("start_lat grant valid", 32'(eng_cmd_valid), 32'd0);
        chk("start_lat grant busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("start_lat valid", 32'(eng_cmd_valid), 32'd1);
        chk("start_lat op", 32'(eng_op), 32'(OP_START));
      end
      check_txn(vt[v].id, vt[v].exp_nack, vt[v].exp_rd, $sformatf("vec%0d", v));
      req = '0;
    end

    // Continuous requests from everybody: strict rotation with wrap.
    cfg_stall = 0; cfg_lat = 0; cfg_nack_a = 0; cfg_nack_d = 0; cfg_rd = 8'hC3;
    set_req(0, 1'b0, 7'h10, 8'h01);
    set_req(1, 1'b0, 7'h11, 8'h02);
    set_req(2, 1'b1, 7'h12, 8'h00);
    set_req(3, 1'b0, 7'h13, 8'h04);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      er = m_rw[rr_exp[k]] ? cfg_rd : m_rdata;
      check_txn(rr_exp[k], 1'b0, er, $sformatf("rr%0d", k));
    end
    req = '0;

    // Reset while the DATA response is pending.
    cfg_lat = 20;
    set_req(3, 1'b0, 7'h33, 8'h44);
    req = 4'b1000;
    cyc = 0;
    while (log_q.size() < 3 && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk("mid_reset reached_data", 32'(log_q.size() >= 3), 32'd1);
    rstn = 0; req = '0;
    @(negedge clk);
    rstn = 1;
    chk_reset_outputs("mid_reset");
    m_ptr = 0; m_rdata = '0; cfg_lat = 0;
    log_q.delete();
    set_req(0, 1'b0, 7'h05, 8'h06);
    set_req(3, 1'b0, 7'h06, 8'h07);
    req = 4'b1001;
    check_txn(0, 1'b0, 8'h00, "post_reset");
    req = '0;

    scramble = 1;
    for (int r = 0; r < 40; r++) begin
      rv = 4'($urandom_range(15, 1));
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
      cfg_stall = $urandom_range(3, 0); cfg_lat = $urandom_range(3, 0);
      cfg_nack_a = ($urandom_range(3, 0) == 0); cfg_nack_d = ($urandom_range(3, 0) == 0);
      cfg_rd = 8'($urandom);
      g = model_pick(rv, m_ptr);
      en = cfg_nack_a || (!m_rw[g] && cfg_nack_d);
      er = (m_rw[g] && !en) ? cfg_rd : m_rdata;
      req = rv;
      check_txn(g, en, er, $sformatf("rand%0d", r));
    end
    scramble = 0;
    req = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/i2c_xfer_arbiter.md
Name: i2c_xfer_arbiter

Overview:
- Shares one byte-level I2C master engine between NUM_REQ requesters and sequences single-byte I2C transactions on their behalf.
- Each transaction is: START, address byte {addr, rw}, one data byte written or read, STOP.
- Arbitration is round-robin. Status and read data return to the granted requester.
- Sits between on-chip clients (config, sensor pollers) and the I2C bit/byte engine that drives sda_o/scl_o.

Parameters:
- NUM_REQ, 4: number of requester ports (2..8).
- ADDR_W, 7: I2C target address width; fixed at 7, 10-bit addressing is not supported.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester transaction request; level, held until matching done
- req_rw  in  NUM_REQ  per-requester direction: 1 = read, 0 = write
- req_addr  in  NUM_REQ*7  per-requester target address, requester i at [7i+6:7i]
- req_wdata  in  NUM_REQ*8  per-requester write byte, requester i at [8i+7:8i]
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- nack  out  1  valid with any done bit; 1 = address or data byte was NACKed
- rdata  out  8  read byte; valid with done when rw=1 and nack=0
- busy  out  1  high from grant until the cycle after done
- eng_cmd_valid  out  1  engine command valid
- eng_cmd_ready  in  1  engine accepts the command when valid&ready
- eng_op  out  2  engine opcode: 0 START, 1 WRITE, 2 READ, 3 STOP
- eng_wdata  out  8  byte for WRITE
- eng_last  out  1  on READ, 1 = master sends NACK after the byte; always 1 here
- eng_rsp_valid  in  1  one-cycle response for a completed op
- eng_rsp_nack  in  1  with rsp_valid on WRITE: target NACKed
- eng_rsp_rdata  in  8  with rsp_valid on READ: received byte

Behaviour:
- Reset values: done=0, nack=0, rdata=0, busy=0, eng_cmd_valid=0, eng_op=0, eng_wdata=0, eng_last=0. Round-robin pointer = 0, state = IDLE.
- Reset is taken in any state, including mid-transaction. eng_cmd_valid drops the next cycle. The engine has its own reset and recovers the bus; this block does not issue STOP after reset.
- States: IDLE, GRANT, START, ADDR, DATA, STOP, DONE. In each of START/ADDR/DATA/STOP the block runs two phases:
  - issue phase: eng_cmd_valid=1, with op and data stable, until eng_cmd_ready;
  - wait phase: eng_cmd_valid=0 until eng_rsp_valid.
  Only one op is outstanding at a time. An eng_rsp_valid that arrives while no op is outstanding is ignored.
- IDLE: if any req bit is set, select the first set index at or after the pointer, wrapping modulo NUM_REQ. Register grant id, rw, addr and wdata, then go to GRANT.
  - Requester inputs are captured here. Later changes to req_* have no effect on the current transaction.
- GRANT: busy=1; go to START. The START command is valid 2 cycles after req is first seen in IDLE.
- START: op=0. On response go to ADDR; eng_rsp_nack is ignored for START.
- ADDR: op=1, wdata={addr, rw}. On response:
  - nack=1: set the sticky nack flag and go to STOP;
  - otherwise go to DATA.
- DATA, write: op=1, wdata=captured byte. eng_rsp_nack sets the nack flag.
- DATA, read: op=2, eng_last=1. Capture eng_rsp_rdata into rdata.
- STOP: op=3. On response go to DONE.
- DONE: pulse done[grant]=1 for one cycle, with nack/rdata valid that cycle. Set pointer = grant+1 mod NUM_REQ. Go to IDLE; busy=0 the next cycle.
  - nack and rdata hold their values until the next DONE.
  - rdata is not updated on write or NACKed transactions.
- Fairness: a requester holding req continuously is re-granted only after every other requesting index has been served once.
- If a requester deasserts req mid-transaction, the transaction still completes and done still pulses.
- Simultaneous eng_cmd_ready and eng_rsp_valid in an issue phase: the response is ignored; the engine never does this.

Decomposition:
- Shared package i2c_pkg holds:
  - eng_op encoding constants: OP_START, OP_WRITE, OP_READ, OP_STOP;
  - the arbiter state enum;
  - I2C_RW_READ=1 and I2C_RW_WRITE=0.
- One sub-module: rr_arbiter (NUM_REQ). Inputs: req vector, pointer, enable. Outputs: one-hot grant and grant index, combinational.
- FSM, capture registers and engine handshake live in i2c_xfer_arbiter.

Test Plan:
- Single write: req[0], addr 0x50, rw=0, wdata 0xA5, engine ready immediately, all acks.
  -> ops START, WRITE 0xA0, WRITE 0xA5, STOP; done[0] pulses once, nack=0.
- Single read: req[2], addr 0x1D, rw=1, engine returns 0x3C.
  -> ops START, WRITE 0x3B, READ with eng_last=1, STOP; done[2] pulses with rdata=0x3C, nack=0.
- Address NACK: req[1], addr 0x7F, engine NACKs the address byte.
  -> no DATA op, STOP issued; done[1] pulses with nack=1; rdata unchanged from its prior value.
- Round-robin: req=4'b1111 held continuously.
  -> done order 0,1,2,3,0; after serving 3, index 0 is granted next.
- Backpressure: eng_cmd_ready low for 5 cycles on each op.
  -> eng_cmd_valid and eng_op/eng_wdata stay stable across the stall; the transaction completes correctly.
- Reset mid-DATA: rstn=0 for one cycle while waiting for the DATA response.
  -> next cycle all outputs are at reset values and state is IDLE; a later request is served with pointer=0.
